// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: round-robin arbiter for one AD7091R serial-ADC socket.
// Requesters are served one conversion at a time. A timeout watchdog aborts
// conversions that the socket never answers.
// Optional feature: define ADC_SCHED_AUTO_EN to add a periodic auto-sample slot
// (ports period_i, auto_vld_o, auto_ovr_o) that takes priority over req_i.
module adc_sample_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] ack_o,
  output logic [11:0]     data_o,
  output logic            err_o,
  output logic            busy_o,
  output logic            sock_en_o,
  output logic            sock_rd_en_o,
  input  logic [11:0]     sock_data_i,
  input  logic            sock_rdy_i
`ifdef ADC_SCHED_AUTO_EN
  ,
  input  logic [15:0]     period_i,
  output logic            auto_vld_o,
  output logic            auto_ovr_o
`endif
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [11:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;

  logic              any_req;
  logic [GW-1:0]     pick;
  logic              found;
  int unsigned       idx;

`ifdef ADC_SCHED_AUTO_EN
  logic [15:0]       cnt_q, cnt_d;
  logic              auto_pend_q, auto_pend_d;
  logic              auto_gnt_q, auto_gnt_d;
  logic              auto_vld_q, auto_vld_d;
  logic              auto_ovr_q, auto_ovr_d;
  logic              auto_clr;
  logic              tick;
`endif

  // Round-robin pick: first pending requester at or after ptr, wrapping.
  always_comb begin
    any_req = |req_i;
    pick    = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Next-state and registered-output logic; everything holds while en is low.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    timer_d = timer_q;
    ack_d   = ack_q;
    data_d  = data_q;
    err_d   = err_q;
    rd_en_d = rd_en_q;
`ifdef ADC_SCHED_AUTO_EN
    auto_gnt_d = auto_gnt_q;
    auto_vld_d = auto_vld_q;
    auto_clr   = 1'b0;
`endif
    if (en) begin
      ack_d   = '0;
      err_d   = 1'b0;
      rd_en_d = 1'b0;
`ifdef ADC_SCHED_AUTO_EN
      auto_vld_d = 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
`ifdef ADC_SCHED_AUTO_EN
          if (auto_pend_q) begin
            auto_gnt_d = 1'b1;
            auto_clr   = 1'b1;
            rd_en_d    = 1'b1;
            state_d    = StIssue;
          end else
`endif
          if (any_req) begin
`ifdef ADC_SCHED_AUTO_EN
            auto_gnt_d = 1'b0;
`endif
            gnt_d   = pick;
            rd_en_d = 1'b1;
            state_d = StIssue;
          end
        end
        StIssue: begin
          timer_d = '0;
          state_d = StWait;
        end
        StWait: begin
          // rdy wins over a timeout landing in the same cycle.
          if (sock_rdy_i || (timer_q == TW'(TIMEOUT))) begin
            data_d  = sock_rdy_i ? sock_data_i : 12'h000;
            err_d   = !sock_rdy_i;
            state_d = StResp;
`ifdef ADC_SCHED_AUTO_EN
            if (auto_gnt_q) auto_vld_d = 1'b1;
            else            ack_d      = NREQ'(1) << gnt_q;
`else
            ack_d = NREQ'(1) << gnt_q;
`endif
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        StResp: begin
`ifdef ADC_SCHED_AUTO_EN
          if (!auto_gnt_q)
`endif
          ptr_d   = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = en ? (state_d != StIdle) : busy_q;
  end

`ifdef ADC_SCHED_AUTO_EN
  // Auto-sample period counter; a tick raises auto_pend, a tick onto a pending slot is an overrun.
  always_comb begin
    cnt_d       = cnt_q;
    auto_pend_d = auto_pend_q;
    auto_ovr_d  = auto_ovr_q;
    tick        = 1'b0;
    if (en) begin
      if (period_i == 16'd0) begin
        cnt_d = 16'd0;
      end else if (cnt_q >= period_i - 16'd1) begin
        cnt_d = 16'd0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      auto_ovr_d  = tick && auto_pend_q && !auto_clr;
      auto_pend_d = tick || (auto_pend_q && !auto_clr);
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      timer_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_en_q <= 1'b0;
`ifdef ADC_SCHED_AUTO_EN
      cnt_q       <= '0;
      auto_pend_q <= 1'b0;
      auto_gnt_q  <= 1'b0;
      auto_vld_q  <= 1'b0;
      auto_ovr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      timer_q <= timer_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rd_en_q <= rd_en_d;
`ifdef ADC_SCHED_AUTO_EN
      cnt_q       <= cnt_d;
      auto_pend_q <= auto_pend_d;
      auto_gnt_q  <= auto_gnt_d;
      auto_vld_q  <= auto_vld_d;
      auto_ovr_q  <= auto_ovr_d;
`endif
    end
  end

  assign ack_o        = ack_q;
  assign data_o       = data_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign sock_rd_en_o = rd_en_q;
  assign sock_en_o    = en;
`ifdef ADC_SCHED_AUTO_EN
  assign auto_vld_o   = auto_vld_q;
  assign auto_ovr_o   = auto_ovr_q;
`endif

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a cycle-accurate socket model
// (rdy 38 enabled cycles after the read strobe).
module tb_adc_sample_scheduler;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [11:0] data;
  logic        err;
  logic        busy;
  logic        sock_en;
  logic        rd_en;
  logic [11:0] mdl_data;
  logic        mdl_rdy;
  logic        mdl_on;
  logic        stray_rdy;
  logic        sock_rdy;
  int          mdl_cnt;
`ifdef ADC_SCHED_AUTO_EN
  logic [15:0] period;
  logic        auto_vld;
  logic        auto_ovr;
`endif

  int checks   = 0;
  int failures = 0;

  assign sock_rdy = mdl_rdy | stray_rdy;

  adc_sample_scheduler #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .req_i        (req),
    .ack_o        (ack),
    .data_o       (data),
    .err_o        (err),
    .busy_o       (busy),
    .sock_en_o    (sock_en),
    .sock_rd_en_o (rd_en),
    .sock_data_i  (mdl_data),
    .sock_rdy_i   (sock_rdy)
`ifdef ADC_SCHED_AUTO_EN
    ,
    .period_i     (period),
    .auto_vld_o   (auto_vld),
    .auto_ovr_o   (auto_ovr)
`endif
  );

  always #5 clk = ~clk;

  // Socket model: strobe seen on an enabled edge -> rdy high 38 enabled cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_cnt <= 0;
      mdl_rdy <= 1'b0;
    end else if (en) begin
      if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        mdl_rdy <= (mdl_cnt == 1);
      end else begin
        mdl_rdy <= 1'b0;
        if (rd_en && mdl_on) mdl_cnt <= 37;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Count negedges (starting at start) until an ack appears or limit is hit.
  task automatic wait_ack(input int start, input int limit, output int n);
    n = start;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0000 && n < limit);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int busy_seen;
    rst       = 1'b1;
    en        = 1'b1;
    req       = 4'b0000;
    mdl_data  = 12'h000;
    mdl_on    = 1'b1;
    stray_rdy = 1'b0;
`ifdef ADC_SCHED_AUTO_EN
    period    = 16'd0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_ack",   ack,   0);
    check_eq("rst_data",  data,  0);
    check_eq("rst_err",   err,   0);
    check_eq("rst_busy",  busy,  0);
    check_eq("rst_rd_en", rd_en, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("sock_en_hi", sock_en, 1);
    en = 1'b0;
    #1 check_eq("sock_en_lo", sock_en, 0);
    en = 1'b1;

    // Single request.
    mdl_data = 12'hA5C;
    req      = 4'b0001;
    @(negedge clk);
    check_eq("single_strobe", rd_en, 1);
    check_eq("single_busy",   busy,  1);
    wait_ack(1, 100, n);
    check_eq("single_lat",  n,    40);
    check_eq("single_ack",  ack,  4'b0001);
    check_eq("single_data", data, 12'hA5C);
    check_eq("single_err",  err,  0);
    req = 4'b0000;
    @(negedge clk);
    check_eq("single_pulse", ack,  0);
    check_eq("data_hold",    data, 12'hA5C);

    // Fairness with all four requesting from ptr=0.
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    mdl_data = 12'h100;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(0, 200, n);
      check_eq($sformatf("rr_lat%0d", k),  n,    (k == 0) ? 40 : 41);
      check_eq($sformatf("rr_ack%0d", k),  ack,  32'(1) << (k % 4));
      check_eq($sformatf("rr_data%0d", k), data, 32'h100 + k);
      mdl_data = 12'(12'h101 + k);
    end
    req = 4'b0000;

    // Timeout: socket silent.
    @(negedge clk);
    mdl_on = 1'b0;
    req    = 4'b0100;
    n      = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_en && n < 100);
    check_eq("to_strobe", n, 1);
    wait_ack(0, 200, n);
    check_eq("to_lat",  n,    TIMEOUT + 2);
    check_eq("to_ack",  ack,  4'b0100);
    check_eq("to_err",  err,  1);
    check_eq("to_data", data, 12'h000);
    req    = 4'b0000;
    mdl_on = 1'b1;
    @(negedge clk);
    check_eq("to_err_clr", err, 0);
    mdl_data = 12'h5A3;
    req      = 4'b0001;
    wait_ack(0, 100, n);
    check_eq("after_to_lat",  n,    40);
    check_eq("after_to_ack",  ack,  4'b0001);
    check_eq("after_to_data", data, 12'h5A3);
    check_eq("after_to_err",  err,  0);
    req = 4'b0000;

    // Enable freeze for 10 cycles during WAIT.
    @(negedge clk);
    mdl_data = 12'h3C7;
    req      = 4'b1000;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 20) en = 1'b0;
      if (n == 30) en = 1'b1;
      if (n == 25) begin
        check_eq("frz_busy", busy, 1);
        check_eq("frz_ack",  ack,  0);
      end
    end while (ack == 4'b0000 && n < 200);
    check_eq("frz_lat",  n,    50);
    check_eq("frz_ack2", ack,  4'b1000);
    check_eq("frz_data", data, 12'h3C7);
    req = 4'b0000;

    // Reset 20 cycles into WAIT, then a stray rdy.
    @(negedge clk);
    req = 4'b0010;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_en && n < 100);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check_eq("mid_rst_ack",   ack,   0);
    check_eq("mid_rst_data",  data,  0);
    check_eq("mid_rst_err",   err,   0);
    check_eq("mid_rst_busy",  busy,  0);
    check_eq("mid_rst_rd_en", rd_en, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    stray_rdy = 1'b1;
    @(negedge clk);
    stray_rdy = 1'b0;
    seen      = 0;
    busy_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) seen++;
      if (busy) busy_seen++;
    end
    check_eq("stray_acks", seen,      0);
    check_eq("stray_busy", busy_seen, 0);

    // Request dropped while in flight is still acknowledged.
    mdl_data = 12'h777;
    req      = 4'b0010;
    @(negedge clk);
    check_eq("drop_strobe", rd_en, 1);
    req = 4'b0000;
    wait_ack(1, 100, n);
    check_eq("drop_lat",  n,    40);
    check_eq("drop_ack",  ack,  4'b0010);
    check_eq("drop_data", data, 12'h777);

    // ptr=2, requesters 0 and 1 pending: wrap grants 0.
    @(negedge clk);
    req = 4'b0011;
    wait_ack(0, 100, n);
    check_eq("wrap_ack", ack, 4'b0001);
    req = 4'b0000;

`ifdef ADC_SCHED_AUTO_EN
    // Auto sampling with the FSM otherwise idle.
    @(negedge clk);
    mdl_data = 12'h2B4;
    period   = 16'd100;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!auto_vld && n < 300);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!auto_vld && n < 300);
    check_eq("auto_period", n,    100);
    check_eq("auto_data",   data, 12'h2B4);
    check_eq("auto_noack",  ack,  0);
    // Auto slot alongside requester 1.
    req = 4'b0010;
    begin
      int av;
      int ak;
      int ov;
      int both;
      av = 0; ak = 0; ov = 0; both = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (auto_vld) av++;
        if (ack[1]) ak++;
        if (auto_ovr) ov++;
        if (auto_vld && ack != 4'b0000) both++;
      end
      check_eq("auto_cnt",  32'(av >= 9), 1);
      check_eq("auto_acks", 32'(ak >= 5), 1);
      check_eq("auto_ovr0", ov,           0);
      check_eq("auto_both", both,         0);
      req    = 4'b0000;
      period = 16'd30;
      ov     = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (auto_ovr) ov++;
      end
      check_eq("auto_ovr", 32'(ov > 0), 1);
      period = 16'd0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Arbitrates a single AD7091R serial-ADC socket between NREQ independent requesters. It issues one-cycle read strobes to the socket and waits for the socket's ready pulse. Each 12-bit result goes back to the requester that owned the conversion. It sits between the socket and the consumers that need samples (control loops, telemetry, host register reads), and includes a timeout watchdog so a hung socket cannot deadlock the requesters.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT, 63: WAIT-state cycle limit before abort. Must be >= 40; the socket responds 38 cycles after the read strobe.

Ports:
- clk  in  1  master clock; same clock as the socket.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global clock enable; forwarded to the socket.
- req_i  in  NREQ  level request per requester; hold until ack.
- ack_o  out  NREQ  one-hot, one-enabled-cycle completion pulse.
- data_o  out  12  result; valid while any ack_o or auto_vld_o bit is high.
- err_o  out  1  high together with ack_o/auto_vld_o when the conversion timed out.
- busy_o  out  1  high in every state except IDLE.
- sock_en_o  out  1  equals en (combinational).
- sock_rd_en_o  out  1  read strobe to the socket.
- sock_data_i  in  12  socket result.
- sock_rdy_i  in  1  socket ready pulse.
- period_i  in  16  auto-sample period in clk cycles; 0 disables. Present only with ADC_SCHED_AUTO_EN.
- auto_vld_o  out  1  auto-sample result pulse. Present only with ADC_SCHED_AUTO_EN.
- auto_ovr_o  out  1  auto-tick overrun pulse. Present only with ADC_SCHED_AUTO_EN.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. The FSM advances only when en=1; with en=0 all registers (including outputs) hold.
- IDLE: if any request is pending, grant the first requester at or after round-robin pointer ptr, wrapping NREQ-1 -> 0. Latch the grant index as gnt and go to ISSUE.
- ISSUE: sock_rd_en_o=1 for exactly this one enabled cycle. Clear the timer and go to WAIT.
- WAIT, on sock_rdy_i=1: capture sock_data_i, set err=0, go to RESP.
- WAIT, on timer==TIMEOUT: set data=12'h000, err=1, go to RESP. Otherwise increment the timer.
- RESP: pulse ack_o[gnt] (or auto_vld_o), drive data_o and err_o. Set ptr <= gnt+1 mod NREQ, go to IDLE.
- sock_rdy_i is ignored outside WAIT.
- data_o holds its last value between pulses.
- A requester that keeps req_i high after its ack is re-arbitrated normally and can be granted again only after every other pending requester has been served (fairness).
- A req_i that falls while its conversion is in flight does not abort the conversion; the ack is still issued.

## Timing
- Reset values: state=IDLE, ptr=0, timer=0, ack_o=0, data_o=0, err_o=0, sock_rd_en_o=0, busy_o=0, auto_vld_o=0, auto_ovr_o=0, period counter=0, auto_pend=0.
- All outputs except sock_en_o are registered.
- Latency:
  - req_i high in IDLE cycle t: sock_rd_en_o high in cycle t+1.
  - Socket rdy arrives in cycle t+39.
  - ack_o in cycle t+40.
  - Next ISSUE no earlier than t+42.
- Timeout path: ack_o with err_o=1 arrives TIMEOUT+2 cycles after ISSUE.
- Simultaneous requests: resolved by round-robin order only, one per transaction.
- Reset mid-conversion: returns to IDLE immediately and no ack is issued. A late sock_rdy_i after reset is ignored.

## Configuration
- ADC_SCHED_AUTO_EN defined:
  - Adds period_i, auto_vld_o and auto_ovr_o.
  - A 16-bit counter counts enabled cycles. When it reaches period_i-1 it wraps to 0 and sets auto_pend.
  - auto_pend is an extra arbitration slot that takes priority over all req_i. It is cleared on entry to ISSUE for the auto slot, and its result is reported on auto_vld_o instead of ack_o.
  - A tick while auto_pend is already set pulses auto_ovr_o for one cycle; auto_pend stays set.
  - period_i=0 holds the counter at 0 and never sets auto_pend.
- ADC_SCHED_AUTO_EN undefined: the three ports, the counter and the auto slot are absent; behaviour is otherwise identical.

## Test plan
- Single request: req_i=4'b0001 with the socket model returning 12'hA5C -> ack_o=4'b0001, data_o=12'hA5C, err_o=0, exactly 40 cycles after req_i rises.
- Fairness: req_i=4'b1111 held continuously -> acks in order 0,1,2,3,0, each with a distinct model value, no requester skipped.
- Timeout: socket model never asserts rdy, req_i=4'b0100 -> ack_o=4'b0100, err_o=1, data_o=12'h000, TIMEOUT+2 cycles after the strobe; next grant proceeds normally.
- Enable freeze: drop en for 10 cycles during WAIT -> timer and state unchanged; ack is delayed by exactly 10 cycles and data is correct.
- Reset: assert rst at cycle 20 of WAIT -> all outputs go to their reset values immediately; a stray sock_rdy_i 5 cycles later produces no ack.
- Auto mode (macro defined), period_i=100 with req_i=4'b0010 held -> auto_vld_o every 100 cycles with precedence over requester 1. With period_i=30: auto_ovr_o pulses.
